// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
// uart_bit_timer
// Mid-bit sample timer for the UART receiver. When the RCU raises
// enable_timer while the timer is idle, the frame configuration is latched
// and the timer emits one shift_strobe in the middle of every bit after the
// start bit, with packet_done riding on the final strobe. enable_timer is a
// level: holding it low while running aborts the frame, and after a frame
// completes the timer parks in HOLD until enable_timer is released, so a
// still-asserted enable cannot retrigger a second frame.
module uart_bit_timer #(
    parameter int CNT_WIDTH  = 14,
    parameter int MIN_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 enable_timer,
    input  logic [CNT_WIDTH-1:0] bit_period,
    input  logic [3:0]           data_size,
    input  logic                 parity_en,
    input  logic                 two_stop,
    output logic                 shift_strobe,
    output logic                 packet_done,
    output logic [3:0]           bit_index,
    output logic                 busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // One extra bit so that P + P/2 never wraps, even for an all-ones period.
    localparam logic [CNT_WIDTH:0] MIN_P = (CNT_WIDTH + 1)'(MIN_PERIOD);

    logic [1:0]           state;
    logic [CNT_WIDTH:0]   countdown;
    logic [CNT_WIDTH:0]   period;
    logic [3:0]           num_bits;

    logic [CNT_WIDTH:0]   p_ext;
    logic [CNT_WIDTH:0]   p_clamped;
    logic [CNT_WIDTH:0]   first_load;
    logic [3:0]           d_clamped;
    logic [3:0]           n_total;
    logic [3:0]           next_index;

    // Frame parameters as they would be latched at a start edge.
    always_comb begin
        p_ext      = {1'b0, bit_period};
        p_clamped  = (p_ext < MIN_P) ? MIN_P : p_ext;
        // Skip the whole start bit and land half a bit into the first data bit.
        first_load = p_clamped + (p_clamped >> 1) - 1'b1;
        if (data_size < 4'd5) begin
            d_clamped = 4'd5;
        end else if (data_size > 4'd8) begin
            d_clamped = 4'd8;
        end else begin
            d_clamped = data_size;
        end
        // Data + optional parity + first stop + optional second stop.
        n_total    = d_clamped + {3'b000, parity_en} + 4'd1 + {3'b000, two_stop};
        next_index = bit_index + 4'd1;
    end

    // Frame sequencer: start/abort/hold control, bit countdown and output pulses.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= IDLE;
            countdown    <= '0;
            period       <= '0;
            num_bits     <= '0;
            shift_strobe <= 1'b0;
            packet_done  <= 1'b0;
            bit_index    <= '0;
            busy         <= 1'b0;
        end else begin
            shift_strobe <= 1'b0;
            packet_done  <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (enable_timer) begin
                        state     <= RUN;
                        period    <= p_clamped;
                        num_bits  <= n_total;
                        countdown <= first_load;
                        bit_index <= '0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable_timer) begin
                        // Abort: no pulse on the abort cycle.
                        state     <= IDLE;
                        countdown <= '0;
                        busy      <= 1'b0;
                    end else if (countdown != '0) begin
                        countdown <= countdown - 1'b1;
                    end else begin
                        shift_strobe <= 1'b1;
                        bit_index    <= next_index;
                        countdown    <= period - 1'b1;
                        // busy stays high through the done cycle and drops one later.
                        if (next_index == num_bits) begin
                            packet_done <= 1'b1;
                            state       <= HOLD;
                            countdown   <= '0;
                        end
                    end
                end
                HOLD: begin
                    busy <= 1'b0;
                    if (!enable_timer) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bit_timer.sv
`timescale 1ns/1ps
// tb_uart_bit_timer
// Directed frames followed by randomized frames, each cycle checked against
// a frame-level reference: strobe k of a frame started at edge E falls on
// edge E + P + P/2 + (k-1)*P for k = 1..N.
module tb_uart_bit_timer;

    localparam int CNT_WIDTH = 14;

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic                 enable_timer;
    logic [CNT_WIDTH-1:0] bit_period;
    logic [3:0]           data_size;
    logic                 parity_en;
    logic                 two_stop;
    logic                 shift_strobe;
    logic                 packet_done;
    logic [3:0]           bit_index;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    int m_mode  = 0;   // 0 idle, 1 running, 2 holding
    int m_start = 0;
    int m_p     = 0;
    int m_n     = 0;
    int m_idx   = 0;
    logic e_strobe, e_done, e_busy;

    // Observed timing of the current frame, relative to its start edge
    int first_obs = -1;
    int done_obs  = -1;

    uart_bit_timer #(.CNT_WIDTH(CNT_WIDTH), .MIN_PERIOD(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable_timer (enable_timer),
        .bit_period   (bit_period),
        .data_size    (data_size),
        .parity_en    (parity_en),
        .two_stop     (two_stop),
        .shift_strobe (shift_strobe),
        .packet_done  (packet_done),
        .bit_index    (bit_index),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs sampled on that edge,
    // then compare every output.
    task automatic step();
        int d;
        int rel;
        @(posedge clk);
        cyc++;
        #1;
        e_strobe = 1'b0;
        e_done   = 1'b0;
        if (!n_rst) begin
            m_mode = 0;
            m_idx  = 0;
            e_busy = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    e_busy = 1'b0;
                    if (enable_timer) begin
                        m_mode  = 1;
                        m_start = cyc;
                        m_p     = (int'(bit_period) < 4) ? 4 : int'(bit_period);
                        d       = int'(data_size);
                        if (d < 5) d = 5;
                        if (d > 8) d = 8;
                        m_n     = d + int'(parity_en) + 1 + int'(two_stop);
                        m_idx   = 0;
                        e_busy  = 1'b1;
                        first_obs = -1;
                        done_obs  = -1;
                    end
                end
                1: begin
                    if (!enable_timer) begin
                        m_mode = 0;
                        e_busy = 1'b0;
                    end else begin
                        e_busy = 1'b1;
                        rel = cyc - m_start - (m_p + m_p / 2);
                        if (rel >= 0 && (rel % m_p) == 0) begin
                            e_strobe = 1'b1;
                            m_idx++;
                            if (m_idx == m_n) begin
                                e_done = 1'b1;
                                m_mode = 2;
                            end
                        end
                    end
                end
                default: begin
                    e_busy = 1'b0;
                    if (!enable_timer) m_mode = 0;
                end
            endcase
        end
        if (shift_strobe === 1'b1 && first_obs < 0) first_obs = cyc - m_start;
        if (packet_done === 1'b1) done_obs = cyc - m_start;
        check("shift_strobe", {31'd0, shift_strobe}, {31'd0, e_strobe});
        check("packet_done",  {31'd0, packet_done},  {31'd0, e_done});
        check("busy",         {31'd0, busy},         {31'd0, e_busy});
        check("bit_index",    {28'd0, bit_index},    32'(m_idx));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input int p, input int d, input bit par, input bit two);
        bit_period = CNT_WIDTH'(p);
        data_size  = 4'(d);
        parity_en  = par;
        two_stop   = two;
    endtask

    initial begin
        int len;
        n_rst        = 1'b0;
        enable_timer = 1'b0;
        cfg(10, 8, 1'b0, 1'b0);

        // Reset state
        run(3);
        n_rst = 1'b1;
        run(2);

        // P=10, 8 data bits, 1 stop: 9 strobes at 15..95
        enable_timer = 1'b1;
        run(100);
        check("p10_first_rel", 32'(first_obs), 32'd15);
        check("p10_done_rel",  32'(done_obs),  32'd95);
        check("p10_final_idx", {28'd0, bit_index}, 32'd9);
        // Enable still high: parked, no restart
        run(20);
        enable_timer = 1'b0;
        run(3);

        // P=16, 7 data, parity, 2 stop: N=10, first 24, last 168
        cfg(16, 7, 1'b1, 1'b1);
        enable_timer = 1'b1;
        run(175);
        check("p16_first_rel", 32'(first_obs), 32'd24);
        check("p16_done_rel",  32'(done_obs),  32'd168);
        enable_timer = 1'b0;
        run(2);

        // Clamping: P=1 -> 4, D=12 -> 8: first 6, last 6+8*4=38
        cfg(1, 12, 1'b0, 1'b0);
        enable_timer = 1'b1;
        run(45);
        check("clamp_first_rel", 32'(first_obs), 32'd6);
        check("clamp_done_rel",  32'(done_obs),  32'd38);
        enable_timer = 1'b0;
        run(2);

        // Period change mid-frame is ignored until the next frame
        cfg(10, 8, 1'b0, 1'b0);
        enable_timer = 1'b1;
        run(30);
        bit_period = 14'd20;
        run(70);
        check("latch_done_rel", 32'(done_obs), 32'd95);
        enable_timer = 1'b0;
        run(2);
        enable_timer = 1'b1;
        run(200);
        check("p20_first_rel", 32'(first_obs), 32'd30);
        check("p20_done_rel",  32'(done_obs),  32'd190);
        enable_timer = 1'b0;
        run(2);

        // Abort after strobe 3, then restart
        cfg(10, 8, 1'b0, 1'b0);
        enable_timer = 1'b1;
        run(36);
        check("abort_idx3", {28'd0, bit_index}, 32'd3);
        enable_timer = 1'b0;
        run(10);
        check("abort_no_done", 32'(done_obs), 32'hFFFF_FFFF);
        enable_timer = 1'b1;
        run(20);
        check("restart_first_rel", 32'(first_obs), 32'd15);
        enable_timer = 1'b0;
        run(2);

        // One-cycle reset mid-frame with enable held high
        enable_timer = 1'b1;
        run(40);
        n_rst = 1'b0;
        run(1);
        n_rst = 1'b1;
        run(110);
        enable_timer = 1'b0;
        run(2);

        // All-ones period: first strobe at 16383 + 8191
        cfg(16383, 5, 1'b0, 1'b0);
        enable_timer = 1'b1;
        run(24580);
        check("maxp_first_rel", 32'(first_obs), 32'd24574);
        enable_timer = 1'b0;
        run(2);

        // Randomized frames with config churn during the frame
        for (int k = 0; k < 10; k++) begin
            cfg($urandom_range(0, 30), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
            enable_timer = 1'b1;
            len = $urandom_range(20, 420);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    cfg($urandom_range(0, 30), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
                end
                step();
            end
            enable_timer = 1'b0;
            run($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
